// File: rtl/hifi_sd_dac.sv
// hifi_sd_dac: second-order sigma-delta audio DAC.
// Converts a 20-bit offset-binary PCM sample into a 1-bit pulse-density
// stream intended for an external RC low-pass filter. One instance per
// channel. Both integrators saturate rather than wrap, so the loop recovers
// cleanly after being driven to either full-scale extreme.

module hifi_sd_dac #(
    parameter int ACCW      = 24,
    parameter bit DITHER_EN = 1'b1,
    parameter int DITHER_SH = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_ena,
    input  logic [19:0] pcm_in,
    output logic        dac_out
);

    // Extended width: two guard bits above the integrator width so that
    // integ + integ + feedback can never overflow before it is clamped.
    localparam int EXTW = ACCW + 2;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [19:0] PCM_FULL  = 20'h80000;

    // Half of the unsigned input range; the input is re-centred around it
    // and the feedback DAC swings by exactly this amount either way.
    localparam logic signed [EXTW-1:0] HALF_SCALE =
        $signed({{(EXTW-19){1'b0}}, 1'b1, 18'd0});

    // Integrator clamp limits expressed in the extended width.
    localparam logic signed [EXTW-1:0] ACC_MAX =
        $signed({3'b000, {(ACCW-1){1'b1}}});
    localparam logic signed [EXTW-1:0] ACC_MIN =
        $signed({3'b111, {(ACCW-1){1'b0}}});

    // Registered modulator state.
    logic signed [ACCW-1:0] integ1;
    logic signed [ACCW-1:0] integ2;
    logic [15:0]            lfsr;

    // Next-state and datapath intermediates.
    logic [19:0]            pcm_sat;
    logic signed [EXTW-1:0] sample_val;
    logic signed [EXTW-1:0] fb_val;
    logic signed [EXTW-1:0] integ1_ext;
    logic signed [EXTW-1:0] integ2_ext;
    logic signed [EXTW-1:0] sum1;
    logic signed [EXTW-1:0] sum2;
    logic signed [EXTW-1:0] integ1_n;
    logic signed [EXTW-1:0] integ2_n;
    logic signed [EXTW-1:0] dither_val;
    logic signed [EXTW-1:0] quant_in;
    logic                   dac_out_n;
    logic                   lfsr_fb;
    logic [15:0]            lfsr_n;

    // Clamp an extended-width sum into the signed integrator range.
    function automatic logic signed [EXTW-1:0] sat_acc(
        input logic signed [EXTW-1:0] value
    );
        logic signed [EXTW-1:0] result;
        if (value > ACC_MAX) begin
            result = ACC_MAX;
        end else if (value < ACC_MIN) begin
            result = ACC_MIN;
        end else begin
            result = value;
        end
        return result;
    endfunction

    // Input conditioning: saturate out-of-range codes to full scale and
    // remove the midscale offset so the loop works on a signed sample.
    always_comb begin
        pcm_sat    = (pcm_in > PCM_FULL) ? PCM_FULL : pcm_in;
        sample_val = $signed({{(EXTW-20){1'b0}}, pcm_sat}) - HALF_SCALE;
    end

    // One-bit feedback DAC driven by the current registered output.
    always_comb begin
        fb_val = dac_out ? HALF_SCALE : -HALF_SCALE;
    end

    // Two cascaded saturating integrators; the second sees the already
    // clamped first-stage result, which gives the same-edge latency path.
    always_comb begin
        integ1_ext = {{2{integ1[ACCW-1]}}, integ1};
        integ2_ext = {{2{integ2[ACCW-1]}}, integ2};
        sum1       = integ1_ext + sample_val - fb_val;
        integ1_n   = sat_acc(sum1);
        sum2       = integ2_ext + integ1_n - fb_val;
        integ2_n   = sat_acc(sum2);
    end

    // Small signed dither from the low LFSR bits breaks up idle tones;
    // the quantizer is a simple sign test on integrator two plus dither.
    always_comb begin
        if (DITHER_EN) begin
            dither_val = {{(EXTW-DITHER_SH-1){lfsr[DITHER_SH]}}, lfsr[DITHER_SH:0]};
        end else begin
            dither_val = '0;
        end
        quant_in  = integ2_n + dither_val;
        dac_out_n = (quant_in >= 0);
    end

    // Fibonacci LFSR, taps 16/14/13/11, shifting left with the new bit in
    // at the LSB; maximal length so the dither never locks up.
    always_comb begin
        lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
        lfsr_n  = {lfsr[14:0], lfsr_fb};
    end

    // State register: everything advances together on enabled edges and
    // holds otherwise, so the output only ever changes on an enabled step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            integ1  <= '0;
            integ2  <= '0;
            lfsr    <= LFSR_SEED;
            dac_out <= 1'b0;
        end else if (clk_ena) begin
            integ1  <= integ1_n[ACCW-1:0];
            integ2  <= integ2_n[ACCW-1:0];
            lfsr    <= lfsr_n;
            dac_out <= dac_out_n;
        end
    end

endmodule

// File: tb/tb_hifi_sd_dac.sv
// Testbench for hifi_sd_dac: randomized and directed stimulus, with a
// behavioural integer model feeding an expected-bit queue that a separate
// monitor drains on every enabled clock edge.

module tb_hifi_sd_dac;

    localparam int     ACCW      = 24;
    localparam bit     DITHER_EN = 1'b1;
    localparam int     DITHER_SH = 7;
    localparam longint HALF      = 262144;
    localparam longint ACC_HI    = (longint'(1) << (ACCW - 1)) - 1;
    localparam longint ACC_LO    = -(longint'(1) << (ACCW - 1));

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_ena;
    logic [19:0] pcm_in;
    logic        dac_out;

    hifi_sd_dac #(
        .ACCW      (ACCW),
        .DITHER_EN (DITHER_EN),
        .DITHER_SH (DITHER_SH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clk_ena (clk_ena),
        .pcm_in  (pcm_in),
        .dac_out (dac_out)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    bit exp_q[$];

    // Reference model state (plain integers).
    longint m_integ1;
    longint m_integ2;
    int     m_lfsr;
    bit     m_out;

    // Monitor-owned observation state.
    bit mon_step;
    bit exp_bit;
    bit last_exp = 1'b0;
    bit last_bit = 1'b0;
    int ones_total  = 0;
    int steps_total = 0;
    int run_len     = 0;
    int max_run     = 0;
    int mark_seen   = 0;

    // Stimulus-owned window bookkeeping.
    int mark_req   = 0;
    int ones_mark  = 0;
    int steps_mark = 0;
    int win_ones   = 0;
    int win_steps  = 0;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkRange(input string name, input longint actual, input longint lo, input longint hi);
        compared++;
        if (actual < lo || actual > hi) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    function automatic longint clampAcc(input longint v);
        if (v > ACC_HI) return ACC_HI;
        if (v < ACC_LO) return ACC_LO;
        return v;
    endfunction

    task automatic modelReset();
        m_integ1 = 0;
        m_integ2 = 0;
        m_lfsr   = 'hACE1;
        m_out    = 1'b0;
    endtask

    // One modulator step straight from the arithmetic definition.
    task automatic modelStep(input logic [19:0] pcm);
        longint x, s, fb, d;
        int     taps[4];
        int     new_bit;
        x = longint'(pcm);
        if (x > 'h80000) x = 'h80000;
        s  = x - HALF;
        fb = m_out ? HALF : -HALF;
        m_integ1 = clampAcc(m_integ1 + s - fb);
        m_integ2 = clampAcc(m_integ2 + m_integ1 - fb);
        d = 0;
        if (DITHER_EN) begin
            d = longint'(m_lfsr % (1 << (DITHER_SH + 1)));
            if (d >= (1 << DITHER_SH)) d = d - (1 << (DITHER_SH + 1));
        end
        m_out = ((m_integ2 + d) >= 0);
        taps = '{16, 14, 13, 11};
        new_bit = 0;
        foreach (taps[k]) new_bit = new_bit ^ ((m_lfsr >> (taps[k] - 1)) & 1);
        m_lfsr = ((m_lfsr << 1) | new_bit) % 65536;
    endtask

    // Drive one cycle of input at the falling edge; enabled cycles push
    // the model's prediction for the coming rising edge.
    task automatic applyStimulus(input logic [19:0] pcm, input bit ena);
        @(negedge clk);
        pcm_in  = pcm;
        clk_ena = ena;
        if (ena && rst_n) begin
            modelStep(pcm);
            exp_q.push_back(m_out);
        end
    endtask

    task automatic runSteps(input logic [19:0] pcm, input int n, input int period);
        for (int i = 0; i < n; i++) begin
            for (int j = 1; j < period; j++) applyStimulus(pcm, 1'b0);
            applyStimulus(pcm, 1'b1);
        end
    endtask

    task automatic settle();
        @(negedge clk);
        clk_ena = 1'b0;
    endtask

    task automatic markWindow();
        settle();
        ones_mark  = ones_total;
        steps_mark = steps_total;
        mark_req++;
    endtask

    task automatic readWindow();
        settle();
        win_ones  = ones_total - ones_mark;
        win_steps = steps_total - steps_mark;
    endtask

    // Asynchronous reset mid-cycle, held three cycles, released mid-cycle.
    task automatic doReset();
        @(negedge clk);
        clk_ena = 1'b0;
        #2 rst_n = 1'b0;
        #1 checkOutput("async_reset", dac_out, 0);
        exp_q.delete();
        modelReset();
        repeat (3) @(negedge clk);
        #3 rst_n = 1'b1;
        #1 checkOutput("release_glitch", dac_out, 0);
    endtask

    // Monitor: on each enabled edge pop and compare; on disabled edges the
    // output must hold its last value.
    always @(posedge clk) begin
        mon_step = clk_ena && rst_n;
        #1;
        if (!rst_n) begin
            last_exp = 1'b0;
        end else if (mon_step) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL step_queue: got output %0d, expected a queued prediction", dac_out);
            end else begin
                exp_bit = exp_q.pop_front();
                checkOutput("step_bit", dac_out, exp_bit);
                last_exp = exp_bit;
            end
            if (mark_seen != mark_req) begin
                mark_seen = mark_req;
                run_len   = 0;
                max_run   = 0;
            end
            if (run_len != 0 && dac_out == last_bit) run_len++;
            else run_len = 1;
            last_bit = dac_out;
            if (run_len > max_run) max_run = run_len;
            ones_total  += (dac_out === 1'b1) ? 1 : 0;
            steps_total += 1;
        end else begin
            checkOutput("hold_bit", dac_out, last_exp);
        end
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [19:0] rnd_pcm;
        int          rnd_len;

        rst_n   = 1'b0;
        clk_ena = 1'b1;
        pcm_in  = 20'h40000;
        modelReset();

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("reset_hold", dac_out, 0);
        end
        clk_ena = 1'b0;
        #2 rst_n = 1'b1;
        #1 checkOutput("reset_release", dac_out, 0);

        $display("[TB] midscale density");
        runSteps(20'h40000, 64, 1);
        markWindow();
        runSteps(20'h40000, 4096, 1);
        readWindow();
        checkRange("mid_density", win_ones, 2048 - 41, 2048 + 41);
        checkRange("mid_max_run", max_run, 1, 4);

        $display("[TB] three-quarter and quarter density");
        runSteps(20'h60000, 64, 1);
        markWindow();
        runSteps(20'h60000, 4096, 1);
        readWindow();
        checkRange("tq_density", win_ones, 3072 - 41, 3072 + 41);
        runSteps(20'h20000, 64, 1);
        markWindow();
        runSteps(20'h20000, 4096, 1);
        readWindow();
        checkRange("q_density", win_ones, 1024 - 41, 1024 + 41);

        $display("[TB] full-scale extremes");
        doReset();
        runSteps(20'h00000, 2, 1);
        markWindow();
        runSteps(20'h00000, 200, 1);
        readWindow();
        checkRange("zero_all_low", win_ones, 0, 0);
        runSteps(20'h80000, 64, 1);
        markWindow();
        runSteps(20'h80000, 200, 1);
        readWindow();
        checkRange("full_all_high", win_ones, 200, 200);
        runSteps(20'h00000, 64, 1);
        markWindow();
        runSteps(20'h00000, 200, 1);
        readWindow();
        checkRange("zero_recover", win_ones, 0, 0);
        runSteps(20'hFFFFF, 64, 1);
        markWindow();
        runSteps(20'hFFFFF, 200, 1);
        readWindow();
        checkRange("sat_all_high", win_ones, 200, 200);
        doReset();
        runSteps(20'hFFFFF, 2, 1);
        markWindow();
        runSteps(20'hFFFFF, 100, 1);
        readWindow();
        checkRange("sat_from_reset", win_ones, 100, 100);

        $display("[TB] enable gating 1-of-4");
        runSteps(20'h40000, 64, 4);
        markWindow();
        runSteps(20'h40000, 4096, 4);
        readWindow();
        checkRange("gated_steps", win_steps, 4096, 4096);
        checkRange("gated_density", win_ones, 2048 - 41, 2048 + 41);

        $display("[TB] mid-operation reset");
        doReset();
        runSteps(20'h60000, 1000, 1);
        doReset();
        runSteps(20'h60000, 200, 1);

        $display("[TB] randomized segments");
        for (int seg = 0; seg < 40; seg++) begin
            rnd_pcm = 20'($urandom_range(0, 20'hFFFFF));
            rnd_len = int'($urandom_range(16, 96));
            for (int c = 0; c < rnd_len; c++) begin
                applyStimulus(rnd_pcm, ($urandom_range(0, 3) != 0));
            end
        end

        settle();
        settle();
        checkRange("queue_drained", exp_q.size(), 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
